// File: rtl/run_ctrl_pkg.sv
// Shared run-control definitions: state encodings, instruction-buffer bound and helpers.
`ifndef DEF_MAX_INSTS
`define DEF_MAX_INSTS 256
`endif

package run_ctrl_pkg;

  localparam int MAX_INSTS = `DEF_MAX_INSTS;

  typedef enum logic [1:0] {
    RC_IDLE  = 2'd0,
    RC_RESET = 2'd1,
    RC_RUN   = 2'd2,
    RC_DONE  = 2'd3
  } rc_state_t;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  function automatic logic depth_ok(input int depth);
    return (depth > 1) && (depth <= MAX_INSTS) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/run_ctrl_core.sv
// Minimal single-cycle RV32 core (addi, add/sub, lui, jal, beq/bne, ebreak).
// Synchronous reset loads the initial PC and clears the register file; ebreak holds the PC.
import run_ctrl_pkg::*;

module Core #(
  parameter int N_INSTS = MAX_INSTS
) (
  input  logic                     _clk,
  input  logic                     _reset,
  input  logic [31:0]              _init_pc,
  input  logic [N_INSTS-1:0][31:0] _insts,
  input  logic                     _en_trace,
  input  logic                     _en_trace_fetch,
  output logic [31:0]              PC_,
  output logic [31:0][31:0]        GPR_,
  output logic                     sig_ebreak_
);

  localparam int IDX_W = $clog2(N_INSTS);

  logic [31:0] inst, rs1_v, rs2_v, imm_i, imm_b, imm_j, next_pc, wr_dat;
  logic [4:0]  rd, rs1, rs2;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic        wr_en;

  // Trace hooks are consumed by the simulator harness, not by this datapath.
  logic unused_trace;
  assign unused_trace = _en_trace ^ _en_trace_fetch;

  assign inst  = _insts[PC_[IDX_W+1:2]];
  assign opc   = inst[6:0];
  assign rd    = inst[11:7];
  assign f3    = inst[14:12];
  assign rs1   = inst[19:15];
  assign rs2   = inst[24:20];
  assign f7    = inst[31:25];
  assign rs1_v = GPR_[rs1];
  assign rs2_v = GPR_[rs2];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign sig_ebreak_ = (inst == INST_EBREAK);

  always_comb begin
    wr_en   = 1'b0;
    wr_dat  = '0;
    next_pc = PC_ + 32'd4;
    case (opc)
      7'h13: if (f3 == 3'd0) begin
        wr_en  = 1'b1;
        wr_dat = rs1_v + imm_i;
      end
      7'h33: if (f3 == 3'd0 && f7 == 7'h00) begin
        wr_en  = 1'b1;
        wr_dat = rs1_v + rs2_v;
      end else if (f3 == 3'd0 && f7 == 7'h20) begin
        wr_en  = 1'b1;
        wr_dat = rs1_v - rs2_v;
      end
      7'h37: begin
        wr_en  = 1'b1;
        wr_dat = {inst[31:12], 12'b0};
      end
      7'h6f: begin
        wr_en   = 1'b1;
        wr_dat  = PC_ + 32'd4;
        next_pc = PC_ + imm_j;
      end
      7'h63: begin
        if ((f3 == 3'd0 && rs1_v == rs2_v) || (f3 == 3'd1 && rs1_v != rs2_v))
          next_pc = PC_ + imm_b;
      end
      default: ;
    endcase
  end

  always_ff @(posedge _clk) begin
    if (_reset) begin
      PC_  <= _init_pc;
      GPR_ <= '0;
    end else if (!sig_ebreak_) begin
      PC_ <= next_pc;
      if (wr_en && rd != 5'd0) GPR_[rd] <= wr_dat;
    end
  end

endmodule

// File: rtl/run_ctrl_fsm.sv
// Run-control sequencer: state, RUN cycle counter, termination flags.
// The cycle-limit watchdog exists only when RUNCTL_WATCHDOG_EN is defined.
import run_ctrl_pkg::*;

module run_ctrl_fsm #(
  parameter int CYCLE_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        start_pc,
  input  logic [CYCLE_W-1:0] max_cycles,
  input  logic               abort,
  input  logic               ebreak,
  output rc_state_t          state,
  output logic               finished,
  output logic               timeout,
  output logic [CYCLE_W-1:0] cycles,
  output logic [31:0]        init_pc,
  output logic               snap_en
);

  logic wd_hit;

`ifdef RUNCTL_WATCHDOG_EN
  assign wd_hit = (max_cycles != '0) && ((cycles + CYCLE_W'(1)) == max_cycles);
`else
  logic unused_max_cycles;
  assign unused_max_cycles = ^max_cycles;
  assign wd_hit = 1'b0;
`endif

  // Strobe on the RUN->DONE edge so the top can freeze the core's state.
  assign snap_en = (state == RC_RUN) && !abort && (ebreak || wd_hit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RC_IDLE;
      finished <= 1'b0;
      timeout  <= 1'b0;
      cycles   <= '0;
      init_pc  <= '0;
    end else if (abort) begin
      state    <= RC_IDLE;
      finished <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        RC_IDLE, RC_DONE: begin
          if (start) begin
            state    <= RC_RESET;
            init_pc  <= start_pc;
            cycles   <= '0;
            finished <= 1'b0;
            timeout  <= 1'b0;
          end
        end
        RC_RESET: state <= RC_RUN;
        RC_RUN: begin
          if (~&cycles) cycles <= cycles + CYCLE_W'(1);
          if (ebreak) begin
            state    <= RC_DONE;
            finished <= 1'b1;
          end else if (wd_hit) begin
            state   <= RC_DONE;
            timeout <= 1'b1;
          end
        end
        default: state <= RC_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/run_ctrl_top.sv
// Run-control top: word-wise load buffer, core sequencing, final-state snapshot.
// Build with RUNCTL_WATCHDOG_EN defined to enable the _max_cycles watchdog.
import run_ctrl_pkg::*;

module run_ctrl_top #(
  parameter int INST_DEPTH = 256,
  parameter int ADDR_W     = $clog2(INST_DEPTH),
  parameter int CYCLE_W    = 32
) (
  input  logic               _clk,
  input  logic               _reset,
  input  logic               _load_valid,
  input  logic [ADDR_W-1:0]  _load_addr,
  input  logic [31:0]        _load_data,
  output logic               load_ready_,
  input  logic               _start,
  input  logic [31:0]        _start_pc,
  input  logic [CYCLE_W-1:0] _max_cycles,
  input  logic               _abort,
  input  logic               _en_trace,
  input  logic               _en_trace_fetch,
  output logic [1:0]         state_,
  output logic               finished_,
  output logic               timeout_,
  output logic [CYCLE_W-1:0] cycles_,
  output logic [31:0]        PC_,
  output logic [31:0]        GPR_ [32]
);

  if (!depth_ok(INST_DEPTH)) begin : g_depth_check
    $error("INST_DEPTH must be a power of two no larger than DEF_MAX_INSTS");
  end

  rc_state_t                  state;
  logic [31:0]                init_pc, core_pc, snap_pc;
  logic [31:0][31:0]          core_gpr, snap_gpr;
  logic                       core_ebreak, core_rst, snap_en, live;
  logic [31:0]                inst_buf [INST_DEPTH];
  logic [MAX_INSTS-1:0][31:0] core_insts;

  run_ctrl_fsm #(.CYCLE_W(CYCLE_W)) u_fsm (
    .clk        (_clk),
    .reset      (_reset),
    .start      (_start),
    .start_pc   (_start_pc),
    .max_cycles (_max_cycles),
    .abort      (_abort),
    .ebreak     (core_ebreak),
    .state      (state),
    .finished   (finished_),
    .timeout    (timeout_),
    .cycles     (cycles_),
    .init_pc    (init_pc),
    .snap_en    (snap_en)
  );

  assign state_      = state;
  assign load_ready_ = (state == RC_IDLE) || (state == RC_DONE);
  assign live        = (state == RC_RUN);
  assign core_rst    = _reset | !live;

  // No reset on the buffer: a program survives host resets and reruns.
  always_ff @(posedge _clk) begin
    if (_load_valid && load_ready_) inst_buf[_load_addr] <= _load_data;
  end

  for (genvar i = 0; i < MAX_INSTS; i++) begin : g_insts
    if (i < INST_DEPTH) begin : g_buf
      assign core_insts[i] = inst_buf[i];
    end else begin : g_zero
      assign core_insts[i] = '0;
    end
  end

  Core #(.N_INSTS(MAX_INSTS)) u_core (
    ._clk            (_clk),
    ._reset          (core_rst),
    ._init_pc        (init_pc),
    ._insts          (core_insts),
    ._en_trace       (_en_trace),
    ._en_trace_fetch (_en_trace_fetch),
    .PC_             (core_pc),
    .GPR_            (core_gpr),
    .sig_ebreak_     (core_ebreak)
  );

  always_ff @(posedge _clk or posedge _reset) begin
    if (_reset) begin
      snap_pc  <= '0;
      snap_gpr <= '0;
    end else if (snap_en) begin
      snap_pc  <= core_pc;
      snap_gpr <= core_gpr;
    end
  end

  assign PC_ = live ? core_pc : snap_pc;

  always_comb begin
    for (int i = 0; i < 32; i++) GPR_[i] = live ? core_gpr[i] : snap_gpr[i];
  end

endmodule
